pgr_uart_cmd_router: RTL and testbench

PGR_UART_CMD_ROUTER -- requirements
Module: pgr_uart_cmd_router

---
 rtl/pgr_uart_cmd_router.sv | 197 +++++++++++++++++++
 tb/tb_pgr_uart_cmd_router.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pgr_uart_cmd_router.sv
// Routes parser commands to one of NCH target channels and forwards the selected channel's response bytes to the UART TX FIFO.
// Optional wait-for-done timeout: define PGR_UART_ROUTER_TIMEOUT_EN.
module pgr_uart_cmd_router #(
  parameter int unsigned AW          = 24,
  parameter int unsigned DW          = 32,
  parameter int unsigned NCH         = 4,
  parameter int unsigned CH_SEL_W    = 2,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [AW-1:0]      cmd_addr,
  input  logic [DW-1:0]      cmd_wdata,
  input  logic               cmd_we,
  input  logic               cmd_en,
  output logic               cmd_done,
  input  logic               board_sel,
  output logic               uart_match,
  output logic [NCH-1:0]     ch_cmd_en,
  output logic [AW-1:0]      ch_addr,
  output logic [DW-1:0]      ch_wdata,
  output logic               ch_we,
  input  logic [NCH-1:0]     ch_done,
  input  logic [NCH*8-1:0]   ch_tx_data,
  input  logic [NCH-1:0]     ch_tx_req,
  output logic [NCH-1:0]     ch_tx_valid,
  output logic [7:0]         tx_fifo_wr_data,
  output logic               tx_fifo_wr_data_req,
  input  logic               tx_fifo_wr_data_valid,
  input  logic               err_clr,
  output logic               err_unmapped,
  output logic               err_timeout
);

  localparam int unsigned IDX_N = 1 << CH_SEL_W;

  if (NCH < 1 || NCH > 8 || NCH > IDX_N || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65536) begin : g_bad_cfg
    $error("pgr_uart_cmd_router: unsupported NCH/CH_SEL_W/TIMEOUT_CYC combination");
  end

  // Bit i set when channel index i addresses an existing channel.
  function automatic logic [IDX_N-1:0] build_map();
    logic [IDX_N-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < IDX_N; i++) m[i] = (i < NCH);
    return m;
  endfunction
  localparam logic [IDX_N-1:0] CH_MAP = build_map();

  typedef enum logic [2:0] {S_IDLE, S_DISPATCH, S_WAIT, S_ERR_RESP, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CH_SEL_W-1:0] idx_q, idx_d;
  logic                match_q, match_d, map_q, map_d;
  logic [CH_SEL_W-1:0] cmd_idx;
  logic [NCH-1:0]      ch_cmd_en_d;
  logic [AW-1:0]       ch_addr_d;
  logic [DW-1:0]       ch_wdata_d;
  logic                ch_we_d, cmd_done_d, err_unmapped_d, set_unmapped;
  logic [7:0]          sel_data;
  logic                sel_req, sel_done;

  assign cmd_idx    = cmd_addr[AW-2 -: CH_SEL_W];
  assign uart_match = (cmd_addr[AW-1] == board_sel);

  // Selected-channel view; only channel idx_q is ever looked at.
  always_comb begin
    sel_data = '0;
    sel_req  = 1'b0;
    sel_done = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (idx_q == CH_SEL_W'(i)) begin
        sel_data = ch_tx_data[8*i +: 8];
        sel_req  = ch_tx_req[i];
        sel_done = ch_done[i];
      end
    end
  end

  // TX handshake is a pass-through so a byte moves in the same cycle req and valid meet.
  always_comb begin
    tx_fifo_wr_data     = '0;
    tx_fifo_wr_data_req = 1'b0;
    ch_tx_valid         = '0;
    if (state_q == S_WAIT) begin
      tx_fifo_wr_data     = sel_data;
      tx_fifo_wr_data_req = sel_req;
      for (int unsigned i = 0; i < NCH; i++)
        if (idx_q == CH_SEL_W'(i)) ch_tx_valid[i] = tx_fifo_wr_data_valid;
    end else if (state_q == S_ERR_RESP) begin
      tx_fifo_wr_data     = 8'hEE;
      tx_fifo_wr_data_req = 1'b1;
    end
  end

`ifdef PGR_UART_ROUTER_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        set_timeout, err_timeout_d;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    match_d      = match_q;
    map_d        = map_q;
    ch_addr_d    = ch_addr;
    ch_wdata_d   = ch_wdata;
    ch_we_d      = ch_we;
    ch_cmd_en_d  = '0;
    set_unmapped = 1'b0;
`ifdef PGR_UART_ROUTER_TIMEOUT_EN
    set_timeout  = 1'b0;
    cnt_d        = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_en) begin
          idx_d      = cmd_idx;
          match_d    = uart_match;
          map_d      = CH_MAP[cmd_idx];
          ch_addr_d  = cmd_addr;
          ch_wdata_d = cmd_wdata;
          ch_we_d    = cmd_we;
          // Strobe is registered here so it is high during the DISPATCH cycle.
          if (uart_match && CH_MAP[cmd_idx]) ch_cmd_en_d = NCH'(1) << cmd_idx;
          state_d    = S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        if (!match_q)   state_d = S_DONE;
        else if (map_q) state_d = S_WAIT;
        else begin
          set_unmapped = 1'b1;
          state_d      = S_ERR_RESP;
        end
      end
      S_WAIT: begin
        if (sel_done) state_d = S_DONE;
`ifdef PGR_UART_ROUTER_TIMEOUT_EN
        else if (cnt_q == 16'(TIMEOUT_CYC - 1)) begin
          set_timeout = 1'b1;
          state_d     = S_ERR_RESP;
        end else cnt_d = cnt_q + 16'd1;
`endif
      end
      S_ERR_RESP: if (tx_fifo_wr_data_valid) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  assign cmd_done_d     = (state_d == S_DONE);
  assign err_unmapped_d = set_unmapped | (err_unmapped & ~err_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      match_q      <= 1'b0;
      map_q        <= 1'b0;
      ch_cmd_en    <= '0;
      ch_addr      <= '0;
      ch_wdata     <= '0;
      ch_we        <= 1'b0;
      cmd_done     <= 1'b0;
      err_unmapped <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      match_q      <= match_d;
      map_q        <= map_d;
      ch_cmd_en    <= ch_cmd_en_d;
      ch_addr      <= ch_addr_d;
      ch_wdata     <= ch_wdata_d;
      ch_we        <= ch_we_d;
      cmd_done     <= cmd_done_d;
      err_unmapped <= err_unmapped_d;
    end
  end

`ifdef PGR_UART_ROUTER_TIMEOUT_EN
  assign err_timeout_d = set_timeout | (err_timeout & ~err_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      err_timeout <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      err_timeout <= err_timeout_d;
    end
  end
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pgr_uart_cmd_router.sv
// Directed bench for pgr_uart_cmd_router (NCH=4, CH_SEL_W=3, TIMEOUT_CYC=100; channel index in cmd_addr[22:20]).
module tb_pgr_uart_cmd_router;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        cmd_we, cmd_en, cmd_done, board_sel, uart_match;
  logic [3:0]  ch_cmd_en;
  logic [23:0] ch_addr;
  logic [31:0] ch_wdata;
  logic        ch_we;
  logic [3:0]  ch_done;
  logic [31:0] ch_tx_data;
  logic [3:0]  ch_tx_req, ch_tx_valid;
  logic [7:0]  tx_fifo_wr_data;
  logic        tx_fifo_wr_data_req, tx_fifo_wr_data_valid;
  logic        err_clr, err_unmapped, err_timeout;

  int n_cmp = 0;
  int n_fail = 0;

  pgr_uart_cmd_router #(.AW(24), .DW(32), .NCH(4), .CH_SEL_W(3), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_we(cmd_we),
    .cmd_en(cmd_en), .cmd_done(cmd_done), .board_sel(board_sel), .uart_match(uart_match),
    .ch_cmd_en(ch_cmd_en), .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_we(ch_we),
    .ch_done(ch_done), .ch_tx_data(ch_tx_data), .ch_tx_req(ch_tx_req), .ch_tx_valid(ch_tx_valid),
    .tx_fifo_wr_data(tx_fifo_wr_data), .tx_fifo_wr_data_req(tx_fifo_wr_data_req),
    .tx_fifo_wr_data_valid(tx_fifo_wr_data_valid), .err_clr(err_clr),
    .err_unmapped(err_unmapped), .err_timeout(err_timeout));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_we = 1'b0; cmd_en = 1'b0; board_sel = 1'b0;
    ch_done = '0; ch_tx_data = '0; ch_tx_req = '0; tx_fifo_wr_data_valid = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({ch_cmd_en, cmd_done, ch_we, err_unmapped, err_timeout} !== 8'h00) begin n_fail++; $display("FAIL rst_flags: got %b want 00000000", {ch_cmd_en, cmd_done, ch_we, err_unmapped, err_timeout}); end
    n_cmp++; if ({ch_addr, ch_wdata} !== 56'h0) begin n_fail++; $display("FAIL rst_regs: got %h want 0", {ch_addr, ch_wdata}); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    n_cmp++; if ({ch_cmd_en, cmd_done, tx_fifo_wr_data_req, ch_tx_valid} !== 10'h0) begin n_fail++; $display("FAIL rst_release: got %b want 0", {ch_cmd_en, cmd_done, tx_fifo_wr_data_req, ch_tx_valid}); end
  endtask

  task automatic test_dispatch();
    cmd_addr = 24'h100010; cmd_wdata = 32'hDEADBEEF; cmd_we = 1'b1; cmd_en = 1'b1;
    #1;
    n_cmp++; if (uart_match !== 1'b1) begin n_fail++; $display("FAIL disp_match: got %b want 1", uart_match); end
    tick(); cmd_en = 1'b0; cmd_we = 1'b0;
    n_cmp++; if (ch_cmd_en !== 4'b0010) begin n_fail++; $display("FAIL disp_onehot: got %b want 0010", ch_cmd_en); end
    n_cmp++; if ({ch_addr, ch_wdata, ch_we} !== {24'h100010, 32'hDEADBEEF, 1'b1}) begin n_fail++; $display("FAIL disp_copy: got %h %h %b want 100010 deadbeef 1", ch_addr, ch_wdata, ch_we); end
    tick();
    n_cmp++; if (ch_cmd_en !== 4'b0000) begin n_fail++; $display("FAIL disp_strobe_len: got %b want 0000", ch_cmd_en); end
    cmd_addr = 24'h300000; cmd_en = 1'b1; ch_done = 4'b0001;
    tick(); cmd_en = 1'b0; ch_done = 4'b0000;
    n_cmp++; if ({cmd_done, ch_cmd_en} !== 5'b0) begin n_fail++; $display("FAIL wait_ignore: got done=%b en=%b want 0 0000", cmd_done, ch_cmd_en); end
    n_cmp++; if (ch_addr !== 24'h100010) begin n_fail++; $display("FAIL wait_hold_addr: got %h want 100010", ch_addr); end
    ch_done = 4'b0010;
    tick(); ch_done = 4'b0000;
    n_cmp++; if (cmd_done !== 1'b1) begin n_fail++; $display("FAIL disp_done: got %b want 1", cmd_done); end
    tick();
    n_cmp++; if (cmd_done !== 1'b0) begin n_fail++; $display("FAIL disp_done_len: got %b want 0", cmd_done); end
    // Channel 0 via index field 3'b000.
    cmd_addr = 24'h010010; cmd_en = 1'b1;
    tick(); cmd_en = 1'b0;
    n_cmp++; if (ch_cmd_en !== 4'b0001) begin n_fail++; $display("FAIL disp_ch0: got %b want 0001", ch_cmd_en); end
    tick(); ch_done = 4'b0001;
    tick(); ch_done = 4'b0000;
    tick();
  endtask

  task automatic test_mismatch();
    cmd_addr = 24'h810000; cmd_en = 1'b1;
    #1;
    n_cmp++; if (uart_match !== 1'b0) begin n_fail++; $display("FAIL mm_match: got %b want 0", uart_match); end
    tick(); cmd_en = 1'b0;
    n_cmp++; if ({ch_cmd_en, tx_fifo_wr_data_req, cmd_done} !== 6'b0) begin n_fail++; $display("FAIL mm_t1: got %b want 000000", {ch_cmd_en, tx_fifo_wr_data_req, cmd_done}); end
    tick();
    n_cmp++; if ({cmd_done, ch_cmd_en, tx_fifo_wr_data_req} !== 6'b100000) begin n_fail++; $display("FAIL mm_t2: got %b want 100000", {cmd_done, ch_cmd_en, tx_fifo_wr_data_req}); end
    tick();
  endtask

  task automatic test_unmapped();
    int xfers = 0;
    cmd_addr = 24'h600000; cmd_en = 1'b1;
    tick(); cmd_en = 1'b0;
    n_cmp++; if ({ch_cmd_en, err_unmapped} !== 5'b0) begin n_fail++; $display("FAIL um_disp: got %b want 00000", {ch_cmd_en, err_unmapped}); end
    tick();
    n_cmp++; if ({err_unmapped, tx_fifo_wr_data_req, tx_fifo_wr_data} !== {2'b11, 8'hEE}) begin n_fail++; $display("FAIL um_resp: got flag=%b req=%b data=%h want 1 1 ee", err_unmapped, tx_fifo_wr_data_req, tx_fifo_wr_data); end
    tick();
    n_cmp++; if ({tx_fifo_wr_data_req, cmd_done} !== 2'b10) begin n_fail++; $display("FAIL um_hold: got req=%b done=%b want 1 0", tx_fifo_wr_data_req, cmd_done); end
    tx_fifo_wr_data_valid = 1'b1;
    #1; if (tx_fifo_wr_data_req && tx_fifo_wr_data_valid) xfers++;
    tick(); tx_fifo_wr_data_valid = 1'b0;
    n_cmp++; if ({cmd_done, tx_fifo_wr_data_req} !== 2'b10 || xfers != 1) begin n_fail++; $display("FAIL um_done: got done=%b req=%b bytes=%0d want 1 0 1", cmd_done, tx_fifo_wr_data_req, xfers); end
    tick(); err_clr = 1'b1;
    tick(); err_clr = 1'b0;
    n_cmp++; if (err_unmapped !== 1'b0) begin n_fail++; $display("FAIL um_clr: got %b want 0", err_unmapped); end
    // Set and clear in the same cycle: set must win.
    err_clr = 1'b1; cmd_addr = 24'h700000; cmd_en = 1'b1;
    tick(); cmd_en = 1'b0;
    tick();
    n_cmp++; if (err_unmapped !== 1'b1) begin n_fail++; $display("FAIL um_set_wins: got %b want 1", err_unmapped); end
    tick();
    n_cmp++; if (err_unmapped !== 1'b0) begin n_fail++; $display("FAIL um_clr_after: got %b want 0", err_unmapped); end
    tx_fifo_wr_data_valid = 1'b1;
    tick(); tx_fifo_wr_data_valid = 1'b0; err_clr = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    cmd_addr = 24'h200000; cmd_en = 1'b1;
    tick(); cmd_en = 1'b0;
    tick();
`ifdef PGR_UART_ROUTER_TIMEOUT_EN
    repeat (99) tick();
    n_cmp++; if ({err_timeout, tx_fifo_wr_data_req, cmd_done} !== 3'b000) begin n_fail++; $display("FAIL to_early: got %b want 000", {err_timeout, tx_fifo_wr_data_req, cmd_done}); end
    tick();
    n_cmp++; if ({err_timeout, tx_fifo_wr_data_req, tx_fifo_wr_data} !== {2'b11, 8'hEE}) begin n_fail++; $display("FAIL to_fire: got flag=%b req=%b data=%h want 1 1 ee", err_timeout, tx_fifo_wr_data_req, tx_fifo_wr_data); end
    tx_fifo_wr_data_valid = 1'b1;
    tick(); tx_fifo_wr_data_valid = 1'b0;
    n_cmp++; if (cmd_done !== 1'b1) begin n_fail++; $display("FAIL to_done: got %b want 1", cmd_done); end
    tick(); err_clr = 1'b1;
    tick(); err_clr = 1'b0;
    n_cmp++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL to_clr: got %b want 0", err_timeout); end
`else
    begin
      int leaks = 0;
      for (int c = 0; c < 150; c++) begin
        tick();
        if (cmd_done || tx_fifo_wr_data_req || err_timeout) leaks++;
      end
      n_cmp++; if (leaks != 0) begin n_fail++; $display("FAIL to_stay_wait: got %0d active cycles want 0", leaks); end
    end
    ch_done = 4'b0100;
    tick(); ch_done = 4'b0000;
    n_cmp++; if ({cmd_done, err_timeout} !== 2'b10) begin n_fail++; $display("FAIL to_late_done: got done=%b flag=%b want 1 0", cmd_done, err_timeout); end
    tick();
`endif
  endtask

  task automatic test_back_to_back_stream();
    logic [7:0] exp_b [4];
    logic [7:0] got [4];
    int k = 0;
    int bad3 = 0;
    int cyc = 0;
    exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    ch_tx_req[3] = 1'b1; ch_tx_data[31:24] = 8'h33;
    cmd_addr = 24'h100000; cmd_en = 1'b1;
    tick(); cmd_en = 1'b0;
    tick();
    while (k < 4 && cyc < 20) begin
      ch_tx_req[1] = 1'b1; ch_tx_data[15:8] = exp_b[k];
      tx_fifo_wr_data_valid = (cyc % 2 == 0);
      #1;
      if (ch_tx_valid[3] !== 1'b0) bad3++;
      if (tx_fifo_wr_data_req && tx_fifo_wr_data_valid && ch_tx_valid[1]) begin
        got[k] = tx_fifo_wr_data;
        k++;
      end
      tick();
      cyc++;
    end
    ch_tx_req[1] = 1'b0; tx_fifo_wr_data_valid = 1'b0;
    n_cmp++; if (k != 4) begin n_fail++; $display("FAIL st_count: got %0d bytes want 4", k); end
    for (int i = 0; i < k; i++) begin
      n_cmp++; if (got[i] !== exp_b[i]) begin n_fail++; $display("FAIL st_byte%0d: got %h want %h", i, got[i], exp_b[i]); end
    end
    n_cmp++; if (bad3 != 0) begin n_fail++; $display("FAIL st_ch3_valid: got %0d cycles want 0", bad3); end
    #1;
    n_cmp++; if (tx_fifo_wr_data_req !== 1'b0) begin n_fail++; $display("FAIL st_ch3_req: got %b want 0", tx_fifo_wr_data_req); end
    ch_done = 4'b0010;
    tick(); ch_done = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid();
    cmd_addr = 24'h100000; cmd_wdata = 32'h12345678; cmd_we = 1'b1; cmd_en = 1'b1;
    tick(); cmd_en = 1'b0; cmd_we = 1'b0;
    tick();
    ch_tx_req[1] = 1'b1; tx_fifo_wr_data_valid = 1'b1;
    #2;
    n_cmp++; if (ch_tx_valid !== 4'b0010) begin n_fail++; $display("FAIL rm_pre: got %b want 0010", ch_tx_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({tx_fifo_wr_data_req, ch_tx_valid, tx_fifo_wr_data, cmd_done, ch_cmd_en} !== 18'h0) begin n_fail++; $display("FAIL rm_out: got %h want 0", {tx_fifo_wr_data_req, ch_tx_valid, tx_fifo_wr_data, cmd_done, ch_cmd_en}); end
    n_cmp++; if ({ch_addr, ch_wdata, ch_we, err_unmapped, err_timeout} !== 59'h0) begin n_fail++; $display("FAIL rm_regs: got %h want 0", {ch_addr, ch_wdata, ch_we, err_unmapped, err_timeout}); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    n_cmp++; if ({tx_fifo_wr_data_req, ch_tx_valid, cmd_done, ch_cmd_en} !== 10'h0) begin n_fail++; $display("FAIL rm_idle: got %b want 0", {tx_fifo_wr_data_req, ch_tx_valid, cmd_done, ch_cmd_en}); end
    ch_tx_req = '0; tx_fifo_wr_data_valid = 1'b0;
    cmd_addr = 24'h300000; cmd_en = 1'b1;
    tick(); cmd_en = 1'b0;
    n_cmp++; if (ch_cmd_en !== 4'b1000) begin n_fail++; $display("FAIL rm_redispatch: got %b want 1000", ch_cmd_en); end
    tick(); ch_done = 4'b1000;
    tick(); ch_done = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_dispatch();
    test_mismatch();
    test_unmapped();
    test_timeout();
    test_back_to_back_stream();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
